ip_header_tx: RTL and testbench
===============================

Name: ip_header_tx

Overview:
Transmit-side IPv4 header generator for the UDP TX path. On a start request it latches the addresses and the UDP datagram length, then computes the header checksum in a multi-cycle accumulator. It then streams the 20-byte IPv4 header (IHL=5, no options) byte-serially over a valid/ready interface to the Ethernet frame assembler. Every header it emits passes the field checks of our IP RX path: 0x45, TOS 0x00, flags/offset 0x0000, protocol UDP.

Parameters:
TOS, 8'h00, type-of-service byte (byte 1)
TTL, 8'hFF, time-to-live byte (byte 8)
IP_PROTO, 8'h11, protocol byte (byte 9), UDP
ID_INIT, 16'h0000, identification value after reset

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  request one header; sampled only while busy=0
payload_len  in  16  UDP datagram length in bytes (UDP header + data); latched on start
ip_s_addr  in  32  source IP address; latched on start
ip_d_addr  in  32  destination IP address; latched on start
data_out  out  8  header byte
data_valid  out  1  data_out holds a valid byte
data_ready  in  1  downstream accepts the byte when data_valid & data_ready
busy  out  1  header in progress; high from the cycle after start is accepted until the last byte is accepted
ip_header_done  out  1  one-cycle pulse after byte 19 is accepted

Behaviour:
- Reset (async assert, sync release) does the following:
  - state=IDLE
  - data_out=0, data_valid=0, busy=0, ip_header_done=0
  - ID counter=ID_INIT, accumulator=0
  - a reset mid-header abandons that header; no done pulse is produced.
- FSM states: IDLE, CALC, FOLD, SEND.
- IDLE: when start=1, latch the inputs and compute total_len = payload_len + 20, mod 2^16 (wraps, no saturation). Go to CALC with stage=0 and acc=0. busy=1 from the next cycle.
- CALC has 5 stages, one per cycle, with a 20-bit unsigned accumulator:
  - stage 0: acc = 0x4500 + total_len
  - stage 1: acc += id + 0x0000
  - stage 2: acc += {TTL, IP_PROTO}
  - stage 3: acc += ip_s_addr[31:16] + ip_s_addr[15:0]
  - stage 4: acc += ip_d_addr[31:16] + ip_d_addr[15:0]
  - after stage 4, go to FOLD.
- FOLD: s = acc[15:0] + acc[19:16]; s = s[15:0] + s[16]; checksum = ~s[15:0]. Register it and go to SEND with idx=0.
- Latency: if start is sampled at edge E0, data_valid is first high after edge E6.
- SEND: data_valid=1. data_out is a mux of the latched fields by idx; idx advances only on a data_valid & data_ready handshake. Byte order (network order, MSB first):
  - idx 0: 0x45
  - idx 1: TOS
  - idx 2–3: total_len
  - idx 4–5: id
  - idx 6–7: 0x00, 0x00
  - idx 8: TTL
  - idx 9: IP_PROTO
  - idx 10–11: checksum
  - idx 12–15: ip_s_addr
  - idx 16–19: ip_d_addr
- Backpressure: while data_valid=1 and data_ready=0, data_out and data_valid hold stable. data_valid never drops before the handshake.
- On the handshake at idx=19:
  - next cycle: state=IDLE, data_valid=0, busy=0, ip_header_done=1 (one cycle)
  - the ID counter increments, wrapping 0xFFFF→0x0000.
- start while busy=1 is ignored (not queued). A start in the ip_header_done cycle is accepted, giving back-to-back headers.
- Input changes after the start cycle have no effect on the header in flight.
- data_ready while data_valid=0 has no effect.

Test Plan:
1. After reset, start with payload_len=0x0010, ip_s_addr=0xC0A80001, ip_d_addr=0xC0A800C7, data_ready=1.
   - required stream: 45 00 00 24 00 00 00 00 FF 11 39 B0 C0 A8 00 01 C0 A8 00 C7
   - data_valid first high 6 cycles after the start edge; ip_header_done pulses once after the last byte.
2. Repeat the same start immediately after the done pulse.
   - id bytes = 00 01, checksum bytes = 39 AF, total_len bytes = 00 24.
3. Toggle data_ready pseudo-randomly during scenario 1.
   - identical 20-byte sequence; data_out is stable whenever data_valid=1 and data_ready=0; still exactly 20 handshakes.
4. Pulse start repeatedly during CALC and SEND, with different addresses.
   - only the first header is emitted, with the first-latched values; busy stays high until the byte-19 handshake.
5. payload_len=0xFFFF.
   - total_len bytes = 00 13; the checksum equals the ones-complement sum recomputed by the bench model.
6. Assert aresetn low at idx=7, then restart with the scenario 1 inputs.
   - outputs are 0 immediately on reset; no done pulse for the aborted header; the new header uses id 0x0000 and checksum 0x39B0.

Source files
------------

// File: rtl/ip_header_tx.sv
// IPv4 header generator for the UDP TX path: latches addresses/length on start,
// accumulates the header checksum over five cycles, then streams 20 bytes MSB-first.
module ip_header_tx #(
  parameter logic [7:0]  TOS      = 8'h00,
  parameter logic [7:0]  TTL      = 8'hFF,
  parameter logic [7:0]  IP_PROTO = 8'h11,
  parameter logic [15:0] ID_INIT  = 16'h0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [15:0] payload_len,
  input  logic [31:0] ip_s_addr,
  input  logic [31:0] ip_d_addr,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        ip_header_done
);

  typedef enum logic [1:0] {IDLE, CALC, FOLD, SEND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [4:0]  idx_q, idx_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] total_len_q, total_len_d;
  logic [15:0] id_q, id_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [15:0] csum_q, csum_d;
  logic        done_q, done_d;

  logic [16:0] fold_s1;
  logic [15:0] fold_s2;
  logic [7:0]  byte_mux;

  // Two-step end-around carry: the 4 overflow bits first, then the possible 17th bit.
  assign fold_s1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold_s2 = fold_s1[15:0] + {15'd0, fold_s1[16]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      stage_q     <= 3'd0;
      idx_q       <= 5'd0;
      acc_q       <= 20'd0;
      total_len_q <= 16'd0;
      id_q        <= ID_INIT;
      s_addr_q    <= 32'd0;
      d_addr_q    <= 32'd0;
      csum_q      <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      total_len_q <= total_len_d;
      id_q        <= id_d;
      s_addr_q    <= s_addr_d;
      d_addr_q    <= d_addr_d;
      csum_q      <= csum_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    total_len_d = total_len_q;
    id_d        = id_q;
    s_addr_d    = s_addr_q;
    d_addr_d    = d_addr_q;
    csum_d      = csum_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          total_len_d = payload_len + 16'd20;
          s_addr_d    = ip_s_addr;
          d_addr_d    = ip_d_addr;
          stage_d     = 3'd0;
          acc_d       = 20'd0;
          state_d     = CALC;
        end
      end
      CALC: begin
        case (stage_q)
          3'd0:    acc_d = 20'h04500 + {4'd0, total_len_q};
          3'd1:    acc_d = acc_q + {4'd0, id_q};
          3'd2:    acc_d = acc_q + {4'd0, TTL, IP_PROTO};
          3'd3:    acc_d = acc_q + {4'd0, s_addr_q[31:16]} + {4'd0, s_addr_q[15:0]};
          default: acc_d = acc_q + {4'd0, d_addr_q[31:16]} + {4'd0, d_addr_q[15:0]};
        endcase
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) state_d = FOLD;
      end
      FOLD: begin
        csum_d  = ~fold_s2;
        idx_d   = 5'd0;
        state_d = SEND;
      end
      SEND: begin
        if (data_ready) begin
          if (idx_q == 5'd19) begin
            state_d = IDLE;
            done_d  = 1'b1;
            id_d    = id_q + 16'd1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_mux = 8'h00;
    case (idx_q)
      5'd0:  byte_mux = 8'h45;
      5'd1:  byte_mux = TOS;
      5'd2:  byte_mux = total_len_q[15:8];
      5'd3:  byte_mux = total_len_q[7:0];
      5'd4:  byte_mux = id_q[15:8];
      5'd5:  byte_mux = id_q[7:0];
      5'd8:  byte_mux = TTL;
      5'd9:  byte_mux = IP_PROTO;
      5'd10: byte_mux = csum_q[15:8];
      5'd11: byte_mux = csum_q[7:0];
      5'd12: byte_mux = s_addr_q[31:24];
      5'd13: byte_mux = s_addr_q[23:16];
      5'd14: byte_mux = s_addr_q[15:8];
      5'd15: byte_mux = s_addr_q[7:0];
      5'd16: byte_mux = d_addr_q[31:24];
      5'd17: byte_mux = d_addr_q[23:16];
      5'd18: byte_mux = d_addr_q[15:8];
      5'd19: byte_mux = d_addr_q[7:0];
      default: byte_mux = 8'h00;
    endcase
  end

  assign data_valid     = (state_q == SEND);
  assign data_out       = data_valid ? byte_mux : 8'h00;
  assign busy           = (state_q != IDLE);
  assign ip_header_done = done_q;

endmodule

// File: tb/tb_ip_header_tx.sv
// Self-checking bench for ip_header_tx: directed table, random headers and reset abort,
// all compared against a byte-level IPv4 header model.
module tb_ip_header_tx;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] payload_len;
  logic [31:0] ip_s_addr;
  logic [31:0] ip_d_addr;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        ip_header_done;

  int errors = 0;
  int checks = 0;
  logic [15:0] id_model = 16'h0000;

  always #5 aclk = ~aclk;

  ip_header_tx dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .payload_len(payload_len),
    .ip_s_addr(ip_s_addr), .ip_d_addr(ip_d_addr), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .ip_header_done(ip_header_done)
  );

  typedef struct {
    logic [15:0] plen;
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] tl;
    logic [15:0] ck;
    bit          ck_from_model;
    int          mode;   // 0: ready always, 1: random ready, 2: random ready + stray starts
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Header built field by field; checksum is the ones-complement of the
  // ones-complement sum of the ten 16-bit words with the checksum field zero.
  function automatic logic [159:0] model_hdr(input logic [15:0] plen, input logic [31:0] s,
                                             input logic [31:0] d, input logic [15:0] id);
    logic [159:0] h;
    logic [15:0]  tl;
    int unsigned  sum;
    tl  = plen + 16'd20;
    h   = {8'h45, 8'h00, tl, id, 16'h0000, 8'hFF, 8'h11, 16'h0000, s, d};
    sum = 0;
    for (int i = 0; i < 10; i++) sum += h[159 - 16*i -: 16];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    h[79:64] = ~sum[15:0];
    return h;
  endfunction

  task automatic stray_start();
    start       = 1'($urandom_range(0, 1));
    payload_len = 16'($urandom);
    ip_s_addr   = $urandom;
    ip_d_addr   = $urandom;
  endtask

  // Entered and left at a negedge; on return the done cycle is current, so a
  // following call issues start in the done cycle (back-to-back).
  task automatic run_header(input logic [15:0] plen, input logic [31:0] s, input logic [31:0] d,
                            input bit ovr_tl, input logic [15:0] tl, input bit ovr_ck,
                            input logic [15:0] ck, input int mode);
    logic [159:0] h;
    logic [7:0]   held;
    bit           held_v;
    int           n, cycles;
    h = model_hdr(plen, s, d, id_model);
    if (ovr_tl) h[143:128] = tl;
    if (ovr_ck) h[79:64]   = ck;
    start = 1'b1; payload_len = plen; ip_s_addr = s; ip_d_addr = d;
    data_ready = (mode == 0);
    @(negedge aclk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("latency_valid_low", data_valid, 1'b0);
      if (mode == 2) stray_start();
      @(negedge aclk);
    end
    chk("latency_valid_high", data_valid, 1'b1);
    n = 0; cycles = 0; held_v = 0; held = 8'h00;
    while (n < 20 && cycles < 2000) begin
      if (held_v) chk("hold_stable", data_out, held);
      chk("valid_in_send", data_valid, 1'b1);
      chk("busy_in_send", busy, 1'b1);
      chk("no_early_done", ip_header_done, 1'b0);
      data_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 2) stray_start();
      if (data_valid && data_ready) begin
        chk($sformatf("byte%0d", n), data_out, h[159 - 8*n -: 8]);
        n++;
        held_v = 0;
      end else begin
        held_v = data_valid;
        held   = data_out;
      end
      @(negedge aclk);
      cycles++;
    end
    start = 1'b0;
    data_ready = 1'b0;
    if (n < 20) begin
      errors++; checks++;
      $display("FAIL handshake_timeout: got %0d bytes expected 20", n);
    end
    chk("done_pulse", ip_header_done, 1'b1);
    chk("busy_after_last", busy, 1'b0);
    chk("valid_after_last", data_valid, 1'b0);
    $display("header id=%04h len=%04h src=%08h dst=%08h ck=%04h mode=%0d bytes=%0d cycles=%0d",
             id_model, h[143:128], s, d, h[79:64], mode, n, cycles);
    id_model = id_model + 16'd1;
  endtask

  initial begin
    logic [15:0] rp;
    logic [31:0] rs, rd;
    int hs, cyc;
    vt[0] = '{16'h0010, 32'hC0A80001, 32'hC0A800C7, 16'h0024, 16'h39B0, 1'b0, 0};
    vt[1] = '{16'h0010, 32'hC0A80001, 32'hC0A800C7, 16'h0024, 16'h39AF, 1'b0, 0};
    vt[2] = '{16'h0010, 32'hC0A80001, 32'hC0A800C7, 16'h0024, 16'h39AE, 1'b0, 1};
    vt[3] = '{16'h0100, 32'h0A000001, 32'h0A000002, 16'h0114, 16'h0000, 1'b1, 2};
    vt[4] = '{16'hFFFF, 32'hC0A80001, 32'hC0A800C7, 16'h0013, 16'h0000, 1'b1, 0};

    aresetn = 1'b0; start = 1'b0; payload_len = 16'h0; ip_s_addr = 32'h0;
    ip_d_addr = 32'h0; data_ready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_valid", data_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", ip_header_done, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 5; i++)
      run_header(vt[i].plen, vt[i].s, vt[i].d, 1'b1, vt[i].tl,
                 !vt[i].ck_from_model, vt[i].ck, vt[i].mode);
    @(negedge aclk);
    chk("done_one_cycle", ip_header_done, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rp = 16'($urandom); rs = $urandom; rd = $urandom;
      run_header(rp, rs, rd, 1'b0, 16'h0, 1'b0, 16'h0, 1 + (i % 2));
    end

    // Abort a header mid-stream with reset once byte 7 is on the bus.
    @(negedge aclk);
    start = 1'b1; payload_len = 16'h0010; ip_s_addr = 32'hC0A80001; ip_d_addr = 32'hC0A800C7;
    data_ready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 7 && cyc < 100) begin
      if (data_valid) hs++;
      @(negedge aclk);
      cyc++;
    end
    chk("abort_reached_idx7", hs, 7);
    aresetn = 1'b0;
    #1;
    chk("abort_data_out", data_out, 8'h00);
    chk("abort_valid", data_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", ip_header_done, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    data_ready = 1'b0;
    id_model = 16'h0000;
    repeat (3) begin
      @(negedge aclk);
      chk("abort_no_done", ip_header_done, 1'b0);
    end
    run_header(16'h0010, 32'hC0A80001, 32'hC0A800C7, 1'b1, 16'h0024, 1'b1, 16'h39B0, 0);

    @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
